// File: rtl/nand8.sv
// nand8 - registered bitwise-NAND slice for the 8-bit ALU datapath.
//
// Computes z = ~(a & b) per bit and registers it together with a one-cycle
// valid strobe and three status flags derived from the new result.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_valid  in   capture a/b on this clk rise
//   a, b      in   WIDTH-bit operands
//   z         out  registered ~(a & b)
//   z_valid   out  one-cycle pulse per capture
//   zero      out  registered (z == 0)
//   all_ones  out  registered (z == all ones)
//   parity    out  registered XOR-reduction of z

// One bit position of the NAND. Kept as its own cell so each lane only ever
// sees its own a[i]/b[i]; no cross-bit dependency is possible.
module nand8_lane (
    input  logic i_a,
    input  logic i_b,
    output logic o_z
);
    assign o_z = ~(i_a & i_b);
endmodule

module nand8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             z_valid,
    output logic             zero,
    output logic             all_ones,
    output logic             parity
);
    logic [WIDTH-1:0] w_z_next;
    logic [WIDTH-1:0] r_z;
    logic             r_z_valid;
    logic             r_zero;
    logic             r_all_ones;
    logic             r_parity;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        nand8_lane u_lane (
            .i_a (a[gi]),
            .i_b (b[gi]),
            .o_z (w_z_next[gi])
        );
    end

    // Flags are taken from the incoming result so they always describe the
    // z loaded on the same edge. The enable gates everything: operands may be
    // X while in_valid is low without touching the stored result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z        <= '0;
            r_z_valid  <= 1'b0;
            r_zero     <= 1'b0;
            r_all_ones <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            r_z_valid <= in_valid;
            if (in_valid) begin
                r_z        <= w_z_next;
                r_zero     <= ~|w_z_next;
                r_all_ones <= &w_z_next;
                r_parity   <= ^w_z_next;
            end
        end
    end

    assign z        = r_z;
    assign z_valid  = r_z_valid;
    assign zero     = r_zero;
    assign all_ones = r_all_ones;
    assign parity   = r_parity;
endmodule

// File: tb/tb_nand8.sv
// tb_nand8 - directed and random checks of nand8 with an expected-result
// queue: each driven cycle pushes the outputs it should produce, and the
// entry is popped and compared one clock later.
module tb_nand8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic [W-1:0] z;
    logic         z_valid, zero, all_ones, parity;

    // {z, z_valid, zero, all_ones, parity}
    typedef logic [W+3:0] obs_t;

    obs_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state for held values across in_valid=0 cycles.
    logic [W-1:0] m_z;
    logic         m_zero, m_ao, m_par;

    nand8 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .z        (z),
        .z_valid  (z_valid),
        .zero     (zero),
        .all_ones (all_ones),
        .parity   (parity)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observed();
        return {z, z_valid, zero, all_ones, parity};
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got z=%b v=%b zero=%b ao=%b par=%b want z=%b v=%b zero=%b ao=%b par=%b",
                   tag, got[W+3:4], got[3], got[2], got[1], got[0],
                   exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle, push what should appear after the edge, then pop and
    // compare 1 time unit after that edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input obs_t exp);
        obs_t e;
        in_valid = v;
        a        = va;
        b        = vb;
        q_exp.push_back(exp);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got=%b want=entry", tag, observed());
        end else begin
            e = q_exp.pop_front();
            check(tag, e);
        end
    endtask

    // Directed capture with hand-derived expected values.
    task automatic dir(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] ez, input logic ezero, input logic eao,
                       input logic epar);
        m_z = ez; m_zero = ezero; m_ao = eao; m_par = epar;
        step(tag, 1'b1, va, vb, {ez, 1'b1, ezero, eao, epar});
    endtask

    // Idle cycle: operands are X, outputs hold, valid drops.
    task automatic idle(input string tag);
        step(tag, 1'b0, 'x, 'x, {m_z, 1'b0, m_zero, m_ao, m_par});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        m_z = '0; m_zero = 1'b0; m_ao = 1'b0; m_par = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0);
        rst = 1'b0;

        // Operands forced to X with in_valid low right after reset.
        idle("post_reset_idle");

        dir("vec2",  8'b00010110, 8'b01010101, 8'b11101011, 1'b0, 1'b0, 1'b0);
        dir("vec3",  8'b10010010, 8'b01000111, 8'b11111101, 1'b0, 1'b0, 1'b1);
        dir("vec4a", 8'b00010010, 8'b01000101, 8'b11111111, 1'b0, 1'b1, 1'b0);
        dir("vec4b", 8'b00110010, 8'b11000101, 8'b11111111, 1'b0, 1'b1, 1'b0);
        dir("vec4c", 8'b00011010, 8'b00000101, 8'b11111111, 1'b0, 1'b1, 1'b0);
        dir("vec5",  8'b11111111, 8'b11111111, 8'b00000000, 1'b1, 1'b0, 1'b0);
        idle("hold1");
        idle("hold2");
        idle("hold3");
        // Single-bit NAND: only bit 0 is 0 -> seven ones, odd parity.
        dir("bit0",  8'b00000001, 8'b00000001, 8'b11111110, 1'b0, 1'b0, 1'b1);

        // Async reset mid-stream with in_valid still high, between edges.
        in_valid = 1'b1; a = 8'h0F; b = 8'hFF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", '0);
        @(posedge clk);
        #1;
        check("reset_held", '0);
        @(negedge clk);
        rst = 1'b0;
        m_z = '0; m_zero = 1'b0; m_ao = 1'b0; m_par = 1'b0;
        // First edge after release is a normal capture edge.
        dir("first_after_reset", 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0);

        // Random back-to-back stream against the reference ~(a & b).
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 97 == 0) begin ra = '1; rb = '1; end
            if (i % 89 == 0) rb = ~ra;
            m_z    = ~(ra & rb);
            m_zero = (m_z == '0);
            m_ao   = (m_z == '1);
            m_par  = ^m_z;
            step("random", 1'b1, ra, rb, {m_z, 1'b1, m_zero, m_ao, m_par});
        end
        idle("final_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
